patch_moment: RTL

- Streaming intensity-centroid block. Consumes one image column of WINDOW_SIZE_Y pixels per accepted beat.
- Each beat produces the zeroth moment (m00), the signed x moment (m10) and the signed y moment (m01) of the sliding WINDOW_SIZE_X x WINDOW_SIZE_Y patch, with all three outputs aligned.
- Successor to the x-only moment block. It adds m01 and m00 outputs and the exact-width rules below. It feeds the orientation stage of the feature pipeline.

---
 rtl/patch_moment.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/patch_moment.sv
// Streaming intensity centroid: each accepted column yields m00, m10 and m01 of
// the sliding WINDOW_SIZE_X x WINDOW_SIZE_Y patch, all three aligned.
module patch_moment #(
  parameter int LUMA_BITS     = 8,
  parameter int WINDOW_SIZE_X = 37,
  parameter int WINDOW_SIZE_Y = 37,
  localparam int HALF_W = WINDOW_SIZE_X / 2,
  localparam int HALF_H = WINDOW_SIZE_Y / 2,
  localparam int SUM_W  = $clog2(WINDOW_SIZE_X * WINDOW_SIZE_Y) + LUMA_BITS,
  localparam int XM_W   = $clog2(HALF_W * (HALF_W + 1) * WINDOW_SIZE_Y / 2) + LUMA_BITS + 1,
  localparam int YM_W   = $clog2(HALF_H * (HALF_H + 1) * WINDOW_SIZE_X / 2) + LUMA_BITS + 1
) (
  input  logic                    clk,
  input  logic                    in_reset,
  input  logic                    in_valid,
  input  logic [LUMA_BITS-1:0]    in_column [WINDOW_SIZE_Y],
  output logic [SUM_W-1:0]        out_sum,
  output logic signed [XM_W-1:0]  out_xmoment,
  output logic signed [YM_W-1:0]  out_ymoment,
  output logic                    out_valid
);

  localparam int TREE_LEVELS = $clog2(WINDOW_SIZE_Y);
  localparam int PIPE_DELAY  = TREE_LEVELS + 4;
  localparam int LEAVES      = 1 << TREE_LEVELS;
  localparam int CSUM_W      = TREE_LEVELS + LUMA_BITS;
  localparam int CYM_W       = $clog2(HALF_H * (HALF_H + 1) / 2) + LUMA_BITS + 1;
  localparam int WIDE_W      = XM_W + SUM_W + 2;
  localparam int VALID_BEAT  = WINDOW_SIZE_X + PIPE_DELAY - 1;
  localparam int CNT_W       = $clog2(VALID_BEAT + 1);

  localparam logic signed [WIDE_W-1:0] K_IN  = WIDE_W'(HALF_W);
  localparam logic signed [WIDE_W-1:0] K_OUT = WIDE_W'(HALF_W + 1);

  if (WINDOW_SIZE_X < 3 || WINDOW_SIZE_X % 2 == 0 ||
      WINDOW_SIZE_Y < 3 || WINDOW_SIZE_Y % 2 == 0) begin : g_bad_size
    $error("patch_moment: window sizes must be odd and >= 3");
  end

  // Heap-ordered trees: node n has children 2n and 2n+1, leaves start at LEAVES,
  // so each tree level is one pipeline stage and the root (node 1) is the column total.
  logic [CSUM_W-1:0]        sum_node [2*LEAVES];
  logic signed [CYM_W-1:0]  ym_node  [2*LEAVES];

  function automatic logic signed [CYM_W-1:0] weighted(input int row,
                                                       input logic [LUMA_BITS-1:0] pix);
    int mag;
    mag = (row < HALF_H ? HALF_H - row : row - HALF_H) * int'(pix);
    return CYM_W'(row < HALF_H ? -mag : mag);
  endfunction

  always_ff @(posedge clk) begin
    if (in_reset) begin
      for (int n = 0; n < 2*LEAVES; n++) begin
        sum_node[n] <= '0;
        ym_node[n]  <= '0;
      end
    end else if (in_valid) begin
      // NOTE: non-blocking assignments let every tree level read last cycle's
      // children, so each level is a true pipeline stage regardless of loop order.
      for (int r = 0; r < WINDOW_SIZE_Y; r++) begin
        sum_node[LEAVES + r] <= CSUM_W'(in_column[r]);
        ym_node[LEAVES + r]  <= weighted(r, in_column[r]);
      end
      for (int r = WINDOW_SIZE_Y; r < LEAVES; r++) begin
        sum_node[LEAVES + r] <= '0;
        ym_node[LEAVES + r]  <= '0;
      end
      for (int n = 1; n < LEAVES; n++) begin
        sum_node[n] <= sum_node[2*n] + sum_node[2*n+1];
        ym_node[n]  <= ym_node[2*n] + ym_node[2*n+1];
      end
    end
  end

  logic [CSUM_W-1:0]        sum_sr [WINDOW_SIZE_X];
  logic signed [CYM_W-1:0]  ym_sr  [WINDOW_SIZE_X];
  logic [CSUM_W-1:0]        col_sum, old_sum;
  logic signed [CYM_W-1:0]  col_ym, old_ym;

  assign col_sum = sum_node[1];
  assign col_ym  = ym_node[1];
  assign old_sum = sum_sr[WINDOW_SIZE_X-1];
  assign old_ym  = ym_sr[WINDOW_SIZE_X-1];

  always_ff @(posedge clk) begin
    // NOTE: the column history is cleared on reset so that a mid-stream reset
    // leaves no pre-reset columns to be subtracted out of the new stream.
    if (in_reset) begin
      for (int i = 0; i < WINDOW_SIZE_X; i++) begin
        sum_sr[i] <= '0;
        ym_sr[i]  <= '0;
      end
    end else if (in_valid) begin
      sum_sr[0] <= col_sum;
      ym_sr[0]  <= col_ym;
      for (int i = 1; i < WINDOW_SIZE_X; i++) begin
        sum_sr[i] <= sum_sr[i-1];
        ym_sr[i]  <= ym_sr[i-1];
      end
    end
  end

  logic [SUM_W-1:0]          m00, d_sum;
  logic signed [XM_W-1:0]    m10, d_xm;
  logic signed [YM_W-1:0]    m01, d_ym;
  logic signed [WIDE_W-1:0]  m10_wide;
  logic [CNT_W-1:0]          cnt;

  // Sliding the window lowers every surviving column's weight by one.
  always_comb begin
    // NOTE: a single unconditional assignment keeps this purely combinational.
    m10_wide = signed'(WIDE_W'(m10))
             + K_IN  * signed'(WIDE_W'(col_sum))
             + K_OUT * signed'(WIDE_W'(old_sum))
             - signed'(WIDE_W'(m00));
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      m00         <= '0;
      m10         <= '0;
      m01         <= '0;
      d_sum       <= '0;
      d_xm        <= '0;
      d_ym        <= '0;
      out_sum     <= '0;
      out_xmoment <= '0;
      out_ymoment <= '0;
      out_valid   <= 1'b0;
      cnt         <= '0;
    end else if (in_valid) begin
      m00         <= m00 + SUM_W'(col_sum) - SUM_W'(old_sum);
      m10         <= XM_W'(m10_wide);
      m01         <= m01 + YM_W'(col_ym) - YM_W'(old_ym);
      d_sum       <= m00;
      d_xm        <= m10;
      d_ym        <= m01;
      out_sum     <= d_sum;
      out_xmoment <= d_xm;
      out_ymoment <= d_ym;
      if (!out_valid) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(VALID_BEAT - 1)) out_valid <= 1'b1;
      end
    end
  end

endmodule
